// File: rtl/dot25_calc.sv
// rtl/dot25_calc.sv - 25-term fixed-point dot product with bias, rounding, saturation and optional ReLU
module dot25_calc #(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 8,
    parameter bit RELU_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WIDTH*51-1:0]   data_from_layer_i,
    output logic [WIDTH-1:0]      data_to_layer_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int ACC_W = 2 * WIDTH + 8;
    localparam int LANES = 5;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) <<< (FRAC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        POST = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [WIDTH*51-1:0]      opnd;
    logic [2:0]               beat;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  biased;
    logic [WIDTH-1:0]         result;
    logic                     accept;

    assign accept = (state == IDLE) && start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = MAC;
            MAC:     if (beat == 3'd4) state_next = POST;
            POST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Five lanes cover terms 5*beat .. 5*beat+4; A words start at 26, B words at 1.
    always_comb begin
        logic signed [WIDTH-1:0]   a_val;
        logic signed [WIDTH-1:0]   b_val;
        logic signed [2*WIDTH-1:0] prod;
        int                        k;
        mac_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            k       = LANES * int'(beat) + i;
            a_val   = opnd[WIDTH*(26+k) +: WIDTH];
            b_val   = opnd[WIDTH*(1+k) +: WIDTH];
            prod    = a_val * b_val;
            mac_sum = mac_sum + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        end
    end

    always_comb begin
        logic signed [WIDTH-1:0] bias;
        bias    = opnd[WIDTH-1:0];
        rounded = (acc + ROUND) >>> FRAC;
        biased  = rounded + {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};
        if (biased > SAT_MAX)      result = SAT_MAX[WIDTH-1:0];
        else if (biased < SAT_MIN) result = SAT_MIN[WIDTH-1:0];
        else                       result = biased[WIDTH-1:0];
        if (RELU_EN && result[WIDTH-1]) result = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd            <= '0;
            beat            <= '0;
            acc             <= '0;
            data_to_layer_o <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            busy_o <= (state_next != IDLE);
            done_o <= (state == POST);
            if (accept) begin
                opnd <= data_from_layer_i;
                acc  <= '0;
                beat <= '0;
            end
            if (state == MAC) begin
                acc  <= acc + mac_sum;
                beat <= beat + 3'd1;
            end
            if (state == POST) data_to_layer_o <= result;
        end
    end

endmodule

// File: tb/tb_dot25_calc.sv
// tb/tb_dot25_calc.sv - scoreboard bench for dot25_calc with and without ReLU
module tb_dot25_calc;

    localparam int W  = 16;
    localparam int NB = W * 51;

    typedef struct {
        logic [W-1:0] res;
        int           acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [NB-1:0] data_in = '0;
    logic [W-1:0]  res_main, res_relu;
    logic          busy_main, busy_relu, done_main, done_relu;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    exp_t q_main[$];
    exp_t q_relu[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot25_calc #(.WIDTH(16), .FRAC(8), .RELU_EN(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_from_layer_i(data_in),
        .data_to_layer_o(res_main), .busy_o(busy_main), .done_o(done_main)
    );

    dot25_calc #(.WIDTH(16), .FRAC(8), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_from_layer_i(data_in),
        .data_to_layer_o(res_relu), .busy_o(busy_relu), .done_o(done_relu)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [NB-1:0] v, input bit relu);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 25; k++)
            acc += longint'($signed(v[W*(26+k) +: W])) * longint'($signed(v[W*(1+k) +: W]));
        r = (acc + 128) >>> 8;
        r += longint'($signed(v[W-1:0]));
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[W-1:0];
    endfunction

    function automatic logic [NB-1:0] uni(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] bias);
        logic [NB-1:0] v;
        v = '0;
        v[W-1:0] = bias;
        for (int k = 0; k < 25; k++) begin
            v[W*(1+k) +: W]  = b;
            v[W*(26+k) +: W] = a;
        end
        return v;
    endfunction

    function automatic logic [NB-1:0] one_term(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [W-1:0] bias);
        logic [NB-1:0] v;
        v = '0;
        v[W-1:0]     = bias;
        v[W +: W]    = b0;
        v[W*26 +: W] = a0;
        return v;
    endfunction

    function automatic logic [NB-1:0] rand_vec();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i += 16) v[i +: 16] = 16'($urandom);
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic send(input logic [NB-1:0] v, input logic [W-1:0] em, input logic [W-1:0] er);
        exp_t e;
        data_in = v;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        data_in = rand_vec();
        e.acc_cyc = cyc;
        e.res = em;
        q_main.push_back(e);
        e.res = er;
        q_relu.push_back(e);
    endtask

    task automatic send_model(input logic [NB-1:0] v);
        send(v, model(v, 1'b0), model(v, 1'b1));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q_main.size() != 0 || q_relu.size() != 0); i++) @(negedge clk);
        if (q_main.size() != 0 || q_relu.size() != 0) begin
            check_val("drain_timeout", 32'(q_main.size() + q_relu.size()), 0);
            q_main.delete();
            q_relu.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done_main) begin
            if (q_main.size() == 0) check_val("spurious_done_main", 1, 0);
            else begin
                e = q_main.pop_front();
                check_val("result_main", res_main, e.res);
                check_val("latency_main", cyc - e.acc_cyc, 6);
            end
        end
        if (rst_n && done_relu) begin
            if (q_relu.size() == 0) check_val("spurious_done_relu", 1, 0);
            else begin
                e = q_relu.pop_front();
                check_val("result_relu", res_relu, e.res);
                check_val("latency_relu", cyc - e.acc_cyc, 6);
            end
        end
    end

    initial begin
        int  bc;
        bit  seen;
        logic [NB-1:0] x;

        #2;
        check_val("rst_res", res_main, 0);
        check_val("rst_busy", busy_main, 0);
        check_val("rst_done", done_main, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic sum and busy width
        send(uni(16'h0100, 16'h0100, 16'h0000), 16'h1900, 16'h1900);
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_main) bc++;
            @(negedge clk);
        end
        check_val("busy_cycles", bc, 6);
        drain();

        // rounding and bias
        send(one_term(16'h0001, 16'h0080, 16'h0010), 16'h0011, 16'h0011);
        drain();
        send(one_term(16'hFFFF, 16'h0080, 16'h0000), 16'h0000, 16'h0000);
        drain();

        // saturation and ReLU
        send(uni(16'h7FFF, 16'h7FFF, 16'h0000), 16'h7FFF, 16'h7FFF);
        drain();
        send(uni(16'h7FFF, 16'h8000, 16'h0000), 16'h8000, 16'h0000);
        drain();

        // input isolation: second start during MAC is ignored
        x = rand_vec();
        send_model(x);
        data_in = rand_vec();
        start_i = 1'b1;
        repeat (2) @(negedge clk);
        start_i = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        // reset during beat 3
        send(uni(16'h0100, 16'h0100, 16'h0000), 16'h1900, 16'h1900);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_res", res_main, 0);
        check_val("midrst_busy", busy_main, 0);
        check_val("midrst_done", done_main, 0);
        q_main.delete();
        q_relu.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(uni(16'h0100, 16'h0100, 16'h0000), 16'h1900, 16'h1900);
        drain();

        // back-to-back: second start in the done cycle
        send(uni(16'h0100, 16'h0100, 16'h0000), 16'h1900, 16'h1900);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (done_main) seen = 1'b1;
            else @(negedge clk);
        end
        check_val("b2b_done_seen", seen, 1);
        send(one_term(16'h0001, 16'h0080, 16'h0010), 16'h0011, 16'h0011);
        for (int i = 0; i < 4; i++) begin
            check_val("b2b_hold", res_main, 16'h1900);
            @(negedge clk);
        end
        drain();

        // random vectors against the model
        for (int n = 0; n < 8; n++) begin
            send_model(rand_vec());
            drain();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
